// File: rtl/key_port.sv
// key_port: memory-mapped push-button input peripheral.
// Synchronizes and debounces four active-low buttons. It keeps a debounced
// level, sticky per-key press events and a running press counter. The CPU
// reads and writes these through the data-memory bus.
// Register map, as offsets from BASE_ADDR:
//   +0 EVT  (write-1-to-clear)
//   +1 LVL  (read-only)
//   +2 CNT  (write loads)
//   +3 CTRL (bit 0 is capture enable)
// The read-data port is named dout because "do" is a reserved word.
module key_port #(
    parameter logic [7:0] BASE_ADDR       = 8'hF0,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] di,
    output logic [7:0] dout,
    output logic       sel
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Number of keys pressing on one edge, 0..4.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // The synchronizer holds raw (active-low) samples, so all-ones means released.
    logic [3:0]      sync1_r;
    logic [3:0]      sync2_r;
    logic [3:0]      key_s;
    logic [3:0]      lvl_r;
    logic [3:0][7:0] db_cnt_r;
    logic [3:0]      evt_r;
    logic [7:0]      cnt_r;
    logic            ctrl_r;

    logic [3:0]      flip_s;
    logic [3:0]      press_s;
    logic            wr_evt_s;
    logic            wr_cnt_s;
    logic            wr_ctrl_s;

    assign key_s = ~sync2_r;
    assign sel   = (addr[7:2] == BASE_ADDR[7:2]);

    // Two-flop synchronizer on the raw buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
        end else begin
            sync1_r <= in;
            sync2_r <= sync1_r;
        end
    end

    // Flip detection and press qualification; a press is a 0->1 flip while capture is enabled.
    always_comb begin
        flip_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if ((key_s[k] != lvl_r[k]) && (db_cnt_r[k] == DB_LAST)) begin
                flip_s[k] = 1'b1;
            end else begin
                flip_s[k] = 1'b0;
            end
        end
        press_s = flip_s & key_s & {4{ctrl_r}};
    end

    // Bus write decode for the writable registers.
    always_comb begin
        wr_evt_s  = 1'b0;
        wr_cnt_s  = 1'b0;
        wr_ctrl_s = 1'b0;
        if (we && sel) begin
            case (addr[1:0])
                2'd0:    wr_evt_s  = 1'b1;
                2'd2:    wr_cnt_s  = 1'b1;
                2'd3:    wr_ctrl_s = 1'b1;
                default: wr_evt_s  = 1'b0;
            endcase
        end else begin
            wr_evt_s = 1'b0;
        end
    end

    // Per-key debounce: count consecutive mismatches, flip the level after DEBOUNCE_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_r    <= 4'b0000;
            db_cnt_r <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (key_s[k] == lvl_r[k]) begin
                    db_cnt_r[k] <= 8'd0;
                end else if (flip_s[k]) begin
                    lvl_r[k]    <= key_s[k];
                    db_cnt_r[k] <= 8'd0;
                end else begin
                    db_cnt_r[k] <= db_cnt_r[k] + 8'd1;
                end
            end
        end
    end

    // Event, counter and control registers. A press beats a same-edge clear,
    // and presses add on top of a same-edge counter load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_r  <= 4'b0000;
            cnt_r  <= 8'h00;
            ctrl_r <= 1'b1;
        end else begin
            evt_r  <= (evt_r & ~(wr_evt_s ? di[3:0] : 4'b0000)) | press_s;
            cnt_r  <= (wr_cnt_s ? di : cnt_r) + {5'b00000, popcount4(press_s)};
            ctrl_r <= wr_ctrl_s ? di[0] : ctrl_r;
        end
    end

    // Combinational read mux; unselected addresses read zero.
    always_comb begin
        dout = 8'h00;
        if (sel) begin
            case (addr[1:0])
                2'd0:    dout = {4'h0, evt_r};
                2'd1:    dout = {4'h0, lvl_r};
                2'd2:    dout = cnt_r;
                2'd3:    dout = {7'h00, ctrl_r};
                default: dout = 8'h00;
            endcase
        end else begin
            dout = 8'h00;
        end
    end

endmodule

// File: tb/tb_key_port.sv
// Testbench for key_port: directed scenarios with literal expectations, then
// randomized traffic. All of it is compared every cycle against a history-window model.
module tb_key_port;

    localparam logic [7:0] BASE = 8'hF0;
    localparam int         DB   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in;
    logic       we;
    logic [7:0] addr;
    logic [7:0] di;
    logic [7:0] dout;
    logic       sel;

    int pass_cnt = 0;
    int total_cnt = 0;

    key_port #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .in(in), .we(we), .addr(addr),
        .di(di), .dout(dout), .sel(sel)
    );

    always #10 clk = ~clk;

    // Model state. hist[0] is the pressed-polarity sample taken on the previous edge.
    // The level flips once the N synchronized samples seen by the debouncer
    // (hist[1..DB]) all disagree with it.
    logic [3:0] hist [0:DB];
    logic [3:0] m_lvl, m_evt;
    logic [7:0] m_cnt;
    logic       m_ctrl;

    task automatic model_reset();
        for (int j = 0; j <= DB; j++) hist[j] = 4'b0000;
        m_lvl = 4'h0; m_evt = 4'h0; m_cnt = 8'h00; m_ctrl = 1'b1;
    endtask

    task automatic model_step();
        logic [3:0] flips, press, clr;
        logic [7:0] base;
        int off;
        if (rst) begin
            model_reset();
            return;
        end
        flips = 4'h0;
        for (int k = 0; k < 4; k++) begin
            bit all_diff = 1'b1;
            for (int j = 1; j <= DB; j++) if (hist[j][k] == m_lvl[k]) all_diff = 1'b0;
            flips[k] = all_diff;
        end
        press = flips & ~m_lvl & {4{m_ctrl}};
        clr = 4'h0;
        base = m_cnt;
        off = int'(addr) - int'(BASE);
        if (we && off >= 0 && off <= 3) begin
            case (off)
                0: clr = di[3:0];
                2: base = di;
                3: m_ctrl = di[0];
                default: ;
            endcase
        end
        m_evt = (m_evt & ~clr) | press;
        m_cnt = base + 8'($countones(press));
        m_lvl = m_lvl ^ flips;
        for (int j = DB; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = ~in;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        int off = int'(a) - int'(BASE);
        case (off)
            0: return {4'h0, m_evt};
            1: return {4'h0, m_lvl};
            2: return m_cnt;
            3: return {7'h00, m_ctrl};
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Per-cycle comparison of the bus outputs against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            begin
                logic [7:0] exp_d;
                logic       exp_s;
                exp_s = (addr >= BASE) && (addr <= BASE + 8'd3);
                exp_d = model_read(addr);
                total_cnt++;
                if (sel === exp_s && dout === exp_d) pass_cnt++;
                else $display("FAIL cycle addr=%h: got dout=%h sel=%b expected dout=%h sel=%b",
                              addr, dout, sel, exp_d, exp_s);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [7:0] exp);
        we = 1'b0;
        addr = a;
        #1;
        chk(nm, dout, exp);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; di = d; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in = 4'b1111; we = 1'b0; addr = 8'h00; di = 8'h00;
        edges(2);
        rst = 1'b0;
        // 1: reset values and decode
        rd("rst_evt", 8'hF0, 8'h00);
        rd("rst_lvl", 8'hF1, 8'h00);
        rd("rst_cnt", 8'hF2, 8'h00);
        rd("rst_ctrl", 8'hF3, 8'h01);
        rd("unsel_do", 8'h10, 8'h00);
        chk("unsel_sel", {7'h00, sel}, 8'h00);
        // 2: key0 press and release, latency 6 edges
        in = 4'b1110;
        edges(5);
        rd("k0_lvl_early", 8'hF1, 8'h00);
        edges(1);
        rd("k0_lvl", 8'hF1, 8'h01);
        rd("k0_evt", 8'hF0, 8'h01);
        rd("k0_cnt", 8'hF2, 8'h01);
        in = 4'b1111;
        edges(6);
        rd("k0_rel_lvl", 8'hF1, 8'h00);
        rd("k0_rel_evt", 8'hF0, 8'h01);
        // 3: glitch then hold on key1
        in = 4'b1101;
        edges(3);
        in = 4'b1111;
        edges(8);
        rd("glitch_lvl", 8'hF1, 8'h00);
        rd("glitch_evt", 8'hF0, 8'h01);
        rd("glitch_cnt", 8'hF2, 8'h01);
        in = 4'b1101;
        edges(6);
        rd("k1_lvl", 8'hF1, 8'h02);
        // 4: counter wrap with four simultaneous presses
        in = 4'b1111;
        edges(6);
        wr(8'hF2, 8'hFE);
        in = 4'b0000;
        edges(6);
        rd("wrap_cnt", 8'hF2, 8'h02);
        rd("all_evt", 8'hF0, 8'h0F);
        // 5: press beats same-edge clear
        in = 4'b1111;
        edges(6);
        wr(8'hF0, 8'h0F);
        rd("clr_evt", 8'hF0, 8'h00);
        in = 4'b1011;
        edges(5);
        wr(8'hF0, 8'h04);
        rd("k2_lvl", 8'hF1, 8'h04);
        rd("set_wins", 8'hF0, 8'h04);
        wr(8'hF0, 8'h04);
        rd("w1c_evt", 8'hF0, 8'h00);
        // 6: capture disabled, then reset mid-debounce
        in = 4'b1111;
        edges(6);
        wr(8'hF3, 8'h00);
        in = 4'b0111;
        edges(6);
        rd("nocap_lvl", 8'hF1, 8'h08);
        rd("nocap_evt", 8'hF0, 8'h00);
        rd("nocap_cnt", 8'hF2, 8'h03);
        rd("nocap_ctrl", 8'hF3, 8'h00);
        in = 4'b1111;
        edges(6);
        in = 4'b0111;
        edges(3);
        rst = 1'b1;
        rd("mid_rst_evt", 8'hF0, 8'h00);
        rd("mid_rst_lvl", 8'hF1, 8'h00);
        rd("mid_rst_cnt", 8'hF2, 8'h00);
        rd("mid_rst_ctrl", 8'hF3, 8'h01);
        edges(1);
        rst = 1'b0;
        edges(5);
        rd("post_rst_early", 8'hF1, 8'h00);
        edges(1);
        rd("post_rst_lvl", 8'hF1, 8'h08);
        rd("post_rst_evt", 8'hF0, 8'h08);
        rd("post_rst_cnt", 8'hF2, 8'h01);
        // Randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                int k = $urandom_range(0, 3);
                in[k] = ~in[k];
            end
            rst = ($urandom_range(0, 499) == 0);
            we = ($urandom_range(0, 7) == 0);
            di = 8'($urandom);
            if ($urandom_range(0, 9) == 0) addr = 8'($urandom);
            else addr = BASE + 8'($urandom_range(0, 3));
            edges(1);
        end
        rst = 1'b0;
        we = 1'b0;
        edges(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
